// File: rtl/rfile_write_buffer.sv
// rfile_write_buffer: in-order write FIFO feeding the register file write port,
// with two youngest-first forwarding lookups over all pending writes.
module rfile_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [ADDR_W-1:0]       in_reg,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  input  logic                    drain_en,
  output logic                    RegWrite,
  output logic [ADDR_W-1:0]       WriteReg,
  output logic [DATA_W-1:0]       WriteData,
  input  logic [ADDR_W-1:0]       fwd_reg_a,
  input  logic [ADDR_W-1:0]       fwd_reg_b,
  output logic                    fwd_hit_a,
  output logic                    fwd_hit_b,
  output logic [DATA_W-1:0]       fwd_data_a,
  output logic [DATA_W-1:0]       fwd_data_b,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] mem_reg  [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic              push;
  logic              pop;

  assign in_ready = rst & (count < CW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = drain_en & (count != '0);
  assign empty    = (count == '0) & ~RegWrite;

  // Port register is oldest, buffer entries scanned oldest to newest so
  // the last match (the youngest pending write) wins.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] r);
    logic [DATA_W:0] res;
    logic [PW-1:0]   idx;
    res = '0;
    if (RegWrite && WriteReg == r)
      res = {1'b1, WriteData};
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count && mem_reg[idx] == r)
        res = {1'b1, mem_data[idx]};
    end
    return res;
  endfunction

  // FIFO pointers, occupancy and the registered write port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count     <= '0;
      head      <= '0;
      tail      <= '0;
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else begin
      RegWrite <= pop;
      if (push) begin
        mem_reg[tail]  <= in_reg;
        mem_data[tail] <= in_data;
        tail           <= tail + 1'b1;
      end
      if (pop) begin
        WriteReg  <= mem_reg[head];
        WriteData <= mem_data[head];
        head      <= head + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Forwarding looks only at registered state; requests are not bypassed.
  always_comb begin
    {fwd_hit_a, fwd_data_a} = lookup(fwd_reg_a);
    {fwd_hit_b, fwd_data_b} = lookup(fwd_reg_b);
  end

endmodule

// File: tb/tb_rfile_write_buffer.sv
// tb_rfile_write_buffer: directed and random stimulus checked against a
// queue-based model of the write buffer and its forwarding.
module tb_rfile_write_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [2:0] r;
    logic [7:0] d;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_reg;
  logic [7:0] in_data;
  logic       in_ready;
  logic       drain_en;
  logic       RegWrite;
  logic [2:0] WriteReg;
  logic [7:0] WriteData;
  logic [2:0] fwd_reg_a;
  logic [2:0] fwd_reg_b;
  logic       fwd_hit_a;
  logic       fwd_hit_b;
  logic [7:0] fwd_data_a;
  logic [7:0] fwd_data_b;
  logic [2:0] count;
  logic       empty;

  int checks = 0;
  int failures = 0;

  ent_t       q[$];
  logic       m_rw;
  logic [2:0] m_reg;
  logic [7:0] m_data;

  rfile_write_buffer #(.DEPTH(DEPTH), .DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_reg(in_reg), .in_data(in_data),
    .in_ready(in_ready), .drain_en(drain_en),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .fwd_reg_a(fwd_reg_a), .fwd_reg_b(fwd_reg_b),
    .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] m_fwd(input logic [2:0] r);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].r == r) return {1'b1, q[i].d};
    if (m_rw && m_reg == r) return {1'b1, m_data};
    return 9'd0;
  endfunction

  task automatic m_clear();
    q.delete();
    m_rw = 1'b0;
    m_reg = '0;
    m_data = '0;
  endtask

  task automatic step(input logic v, input logic [2:0] r,
                      input logic [7:0] d, input logic dr,
                      input logic [2:0] ra, input logic [2:0] rb,
                      input logic rs);
    logic [8:0] fa, fb;
    logic       pop, push;
    @(negedge clk);
    in_valid = v; in_reg = r; in_data = d;
    drain_en = dr; fwd_reg_a = ra; fwd_reg_b = rb; rst = rs;
    #1;
    fa = m_fwd(ra);
    fb = m_fwd(rb);
    check("count", 32'(count), 32'(q.size()));
    check("in_ready", 32'(in_ready),
          32'(rs && q.size() < DEPTH));
    check("empty", 32'(empty), 32'(q.size() == 0 && !m_rw));
    check("RegWrite", 32'(RegWrite), 32'(m_rw));
    check("WriteReg", 32'(WriteReg), 32'(m_reg));
    check("WriteData", 32'(WriteData), 32'(m_data));
    check("fwd_a", {23'd0, fwd_hit_a, fwd_data_a}, 32'(fa));
    check("fwd_b", {23'd0, fwd_hit_b, fwd_data_b}, 32'(fb));
    @(posedge clk);
    if (!rs) begin
      m_clear();
    end else begin
      pop  = dr && q.size() > 0;
      push = v && q.size() < DEPTH;
      m_rw = pop;
      if (pop) begin
        m_reg  = q[0].r;
        m_data = q[0].d;
        void'(q.pop_front());
      end
      if (push) q.push_back('{r: r, d: d});
    end
  endtask

  task automatic idle(input logic dr, input logic [2:0] ra,
                      input logic [2:0] rb);
    step(1'b0, 3'd0, 8'd0, dr, ra, rb, 1'b1);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_reg = '0; in_data = '0;
    drain_en = 1'b0; fwd_reg_a = '0; fwd_reg_b = '0;
    repeat (2) @(posedge clk);
    m_clear();
    step(1'b0, 3'd0, 8'd0, 1'b1, 3'd0, 3'd0, 1'b0);
    #1;
    check("rst_empty", 32'(empty), 32'd1);

    step(1'b1, 3'd3, 8'h5A, 1'b1, 3'd3, 3'd2, 1'b1);
    #1;
    check("t1_hit_k", 32'(fwd_hit_a), 32'd1);
    check("t1_rw_k", 32'(RegWrite), 32'd0);
    idle(1'b1, 3'd3, 3'd2);
    #1;
    check("t1_rw", 32'(RegWrite), 32'd1);
    check("t1_wr", 32'(WriteReg), 32'd3);
    check("t1_wd", 32'(WriteData), 32'h5A);
    check("t1_port_fwd", 32'(fwd_data_a), 32'h5A);
    idle(1'b1, 3'd3, 3'd2);
    #1;
    check("t1_rw_off", 32'(RegWrite), 32'd0);
    check("t1_hit_off", 32'(fwd_hit_a), 32'd0);

    for (int i = 1; i <= 4; i++)
      step(1'b1, 3'(i), 8'(i * 8'h11), 1'b0, 3'd2, 3'd4, 1'b1);
    #1;
    check("fill_cnt", 32'(count), 32'd4);
    check("fill_rdy", 32'(in_ready), 32'd0);
    step(1'b1, 3'd5, 8'h55, 1'b0, 3'd5, 3'd4, 1'b1);
    idle(1'b1, 3'd1, 3'd4);
    #1;
    check("rdy_back", 32'(in_ready), 32'd1);
    repeat (5) idle(1'b1, 3'd4, 3'd5);

    step(1'b1, 3'd5, 8'h10, 1'b0, 3'd5, 3'd6, 1'b1);
    step(1'b1, 3'd5, 8'h20, 1'b0, 3'd5, 3'd6, 1'b1);
    step(1'b1, 3'd6, 8'h30, 1'b0, 3'd5, 3'd6, 1'b1);
    #1;
    check("prio_a", 32'(fwd_data_a), 32'h20);
    check("prio_b", 32'(fwd_data_b), 32'h30);
    idle(1'b0, 3'd7, 3'd6);
    #1;
    check("miss_hit", 32'(fwd_hit_a), 32'd0);
    check("miss_data", 32'(fwd_data_a), 32'd0);
    repeat (5) idle(1'b1, 3'd5, 3'd6);

    for (int i = 0; i < 10; i++) begin
      step(1'b1, 3'(i), 8'(8'hA0 + i), 1'b1, 3'(i), 3'(i + 1), 1'b1);
      #1;
      check("stream_cnt", 32'(count <= 3'd1), 32'd1);
    end
    repeat (3) idle(1'b1, 3'd0, 3'd1);

    for (int i = 0; i < 3; i++)
      step(1'b1, 3'(i), 8'(8'hC0 + i), 1'b0, 3'd1, 3'd2, 1'b1);
    step(1'b0, 3'd0, 8'd0, 1'b0, 3'd1, 3'd2, 1'b0);
    #1;
    check("mrst_cnt", 32'(count), 32'd0);
    check("mrst_empty", 32'(empty), 32'd1);
    check("mrst_rw", 32'(RegWrite), 32'd0);
    repeat (4) idle(1'b1, 3'd1, 3'd2);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, 3'($urandom), 8'($urandom),
           $urandom_range(0, 1) == 1, 3'($urandom), 3'($urandom),
           $urandom_range(0, 99) != 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
